// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-line
// refill engine (LINE_WORDS-word bursts) and single-word data accesses.
module mem_port_arbiter #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_word,
  output logic              i_word_ready,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IFILL = 2'd1,
    DACC  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_i_q, last_i_d;
  logic [WORD_W-1:0] i_word_q, i_word_d;
  logic              i_word_ready_q, i_word_ready_d;
  logic              i_done_q, i_done_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              i_valid, d_valid;

  // A request still high in the cycle its completion pulse is visible is stale.
  assign i_valid = i_miss & ~i_done_q;
  assign d_valid = d_req & ~d_ack_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_i_d       = last_i_q;
    i_word_d       = i_word_q;
    i_word_ready_d = 1'b0;
    i_done_d       = 1'b0;
    d_rdata_d      = d_rdata_q;
    d_ack_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && !(d_valid && last_i_q)) begin
          state_d = IFILL;
          cnt_d   = '0;
        end else if (d_valid) begin
          state_d = DACC;
        end
      end
      IFILL: begin
        if (!i_miss) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (mem_ack) begin
          i_word_d       = mem_rdata;
          i_word_ready_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            i_done_d = 1'b1;
            last_i_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DACC: begin
        if (!d_req) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          state_d  = IDLE;
          d_ack_d  = 1'b1;
          last_i_d = 1'b0;
          if (!d_we) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_i_q       <= 1'b1;
      i_word_q       <= '0;
      i_word_ready_q <= 1'b0;
      i_done_q       <= 1'b0;
      d_rdata_q      <= '0;
      d_ack_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_i_q       <= last_i_d;
      i_word_q       <= i_word_d;
      i_word_ready_q <= i_word_ready_d;
      i_done_q       <= i_done_d;
      d_rdata_q      <= d_rdata_d;
      d_ack_q        <= d_ack_d;
    end
  end

  assign mem_req      = (state_q != IDLE);
  assign mem_we       = (state_q == DACC) && d_we;
  assign mem_addr     = (state_q == IFILL) ? (i_addr + ADDR_W'(cnt_q)) :
                        (state_q == DACC)  ? d_addr : '0;
  assign mem_wdata    = (state_q == DACC) ? d_wdata : '0;
  assign i_word       = i_word_q;
  assign i_word_ready = i_word_ready_q;
  assign i_done       = i_done_q;
  assign d_rdata      = d_rdata_q;
  assign d_ack        = d_ack_q;
  assign dbg_state    = state_q;

endmodule
